lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store controller directly upstream of the word-addressed data memory (1024 x 32-bit, combinational read, synchronous write on WE, read data forced to 0 while WE=1).
- Accepts one RV32I load/store request at a time from the core over a valid/ready handshake.
- Handles LB/LH/LW/LBU/LHU and SB/SH/SW with byte-lane extraction and sign/zero extension.
- Implements sub-word stores as a two-cycle read-modify-write, because the memory has no byte enables.

Parameters:
MEM_WORDS, 1024, number of 32-bit words in the data memory; word index >= MEM_WORDS is an access error.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  core presents a request
req_ready  output  1  controller can accept; high only in IDLE and rst=0
req_we  input  1  1=store, 0=load
req_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  one-cycle pulse, response complete
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  misaligned, illegal funct3, or out of range
mem_a  output  32  word index to memory, {2'b00, addr[31:2]}
mem_we  output  1  memory write enable
mem_wd  output  32  memory write data
mem_rd  input  32  memory read data

Behaviour:
- States: IDLE, LD, ST, RMW_R, RMW_W, RESP.
- IDLE:
  - Acceptance occurs on a rising edge with req_valid & req_ready.
  - On acceptance, register addr, funct3, we and wdata.
  - Error cases go to RESP with err=1: illegal funct3 (011, 11x; for stores any funct3 other than 000/001/010); halfword with addr[0]=1; word with addr[1:0]!=0; word index >= MEM_WORDS.
  - Otherwise: load goes to LD; SW goes to ST; SB/SH go to RMW_R.
- LD:
  - mem_a valid, mem_we=0.
  - At the edge, select the byte/half lane by addr[1:0], sign- or zero-extend, register it into resp_rdata, go to RESP.
- ST: mem_we=1, mem_wd=wdata, go to RESP.
- RMW_R:
  - mem_we=0.
  - At the edge, capture mem_rd and merge wdata[7:0] into byte lane addr[1:0] (SB) or wdata[15:0] into half lane addr[1] (SH).
  - Go to RMW_W.
- RMW_W: mem_we=1, mem_wd=merged word, go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- Response latency after the accept edge: error, 1 cycle; load and SW, 2 cycles; SB/SH, 3 cycles. mem_we is high for exactly one cycle per valid store.
- Outside LD/ST/RMW_R/RMW_W: mem_a=0, mem_we=0, mem_wd=0.
- resp_rdata and resp_err are registered and hold until the next response. resp_rdata=0 on stores and errors.
- A req_valid held high while busy is ignored; it is accepted only in the next IDLE cycle. The earliest back-to-back accept is the cycle after RESP.
- Reset values: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0.
- During any cycle with rst=1: req_ready=0 and mem_we=0 (gated), so no memory write happens on a reset edge.
- Reset mid-operation aborts the request: no response, memory unchanged if the write cycle had not completed.

Test Plan:
- Preload word 7 = 0x8070F020. LW 0x1C -> resp_rdata 0x8070F020, err=0, resp_valid 2 cycles after accept. LB 0x1F -> 0xFFFFFF80. LBU 0x1F -> 0x00000080. LH 0x1E -> 0xFFFF8070. LHU 0x1E -> 0x00008070.
- SB 0x1D wdata 0x000000AB -> word 7 = 0x8070AB20. resp_valid 3 cycles after accept; mem_we high in exactly one cycle. Then SH 0x1E wdata 0x00001234 -> word 7 = 0x1234AB20.
- SW 0x28 wdata 0xDEADBEEF -> word 10 = 0xDEADBEEF, resp_rdata=0, 2-cycle latency.
- Error cases, each giving resp_err=1, resp_rdata=0, no mem_we ever, resp_valid 1 cycle after accept:
  - LW 0x1E
  - LH 0x1F
  - SW 0x1000 (word 1024)
  - funct3=011
- Assert rst during the RMW_W cycle of SB 0x1C wdata 0xFF -> word 7 unchanged, no resp_valid, outputs zero, req_ready high the cycle after rst falls.
- req_valid held high across two requests (LW 0x1C then LW 0x28) -> req_ready low while busy, second accepted the cycle after the first RESP, two distinct resp_valid pulses with correct data.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl
//
// Purpose:
//   Load/store controller sitting directly in front of a word-addressed data
//   memory (combinational read, synchronous write on mem_we, read data forced
//   to zero while mem_we is high). It accepts one RV32I load/store at a time,
//   extracts and extends byte/half/word load data, and performs sub-word
//   stores as a read-modify-write because the memory has no byte enables.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   req_valid   core presents a request
//   req_ready   controller can accept (IDLE and not in reset)
//   req_we      1 = store, 0 = load
//   req_funct3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   req_addr    byte address
//   req_wdata   store data, right-aligned
//   resp_valid  one-cycle pulse marking a completed response
//   resp_rdata  extended load data (0 for stores and errors), held
//   resp_err    misaligned / illegal funct3 / out of range, held
//   mem_a       word index to memory
//   mem_we      memory write enable
//   mem_wd      memory write data
//   mem_rd      memory read data
// ---------------------------------------------------------------------------
module lsu_mem_ctrl #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_a,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD,
    S_ST,
    S_RMW_R,
    S_RMW_W,
    S_RESP
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_e      state_q, state_d;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic [31:0] wdata_q;
  logic [31:0] merged_q, merged_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  // Raw memory-side controls before reset gating.
  logic [31:0] mem_a_c;
  logic        mem_we_c;
  logic [31:0] mem_wd_c;

  logic        accept;
  logic        f3_legal;
  logic        misaligned;
  logic        out_of_range;
  logic        req_bad;
  logic [31:0] word_idx;
  logic [31:0] rd_shifted;
  logic [15:0] rd_half;
  logic [31:0] load_ext;
  logic [31:0] merge_word;

  // ------------------------------------------------------------------------
  // Request decode (evaluated on the live request while IDLE)
  // ------------------------------------------------------------------------
  assign accept = (state_q == S_IDLE) && req_valid;

  always_comb begin
    f3_legal = 1'b0;
    if (req_we) begin
      f3_legal = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W);
    end else begin
      f3_legal = (req_funct3 == F3_B)  || (req_funct3 == F3_H) || (req_funct3 == F3_W) ||
                 (req_funct3 == F3_BU) || (req_funct3 == F3_HU);
    end
  end

  // funct3[1:0] encodes the access size for every legal code; illegal codes
  // are already flagged above, so overlapping here is harmless.
  assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

  assign out_of_range = {2'b00, req_addr[31:2]} >= 32'(MEM_WORDS);

  assign req_bad = !f3_legal || misaligned || out_of_range;

  // ------------------------------------------------------------------------
  // Load lane extraction and store merge (from the registered request)
  // ------------------------------------------------------------------------
  assign word_idx   = {2'b00, addr_q[31:2]};
  assign rd_shifted = mem_rd >> {addr_q[1:0], 3'b000};
  assign rd_half    = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];

  always_comb begin
    load_ext = mem_rd;
    case (funct3_q)
      F3_B:    load_ext = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      F3_BU:   load_ext = {24'h000000, rd_shifted[7:0]};
      F3_H:    load_ext = {{16{rd_half[15]}}, rd_half};
      F3_HU:   load_ext = {16'h0000, rd_half};
      default: load_ext = mem_rd;
    endcase
  end

  always_comb begin
    merge_word = mem_rd;
    if (funct3_q[1:0] == 2'b00) begin
      for (int i = 0; i < 4; i++) begin
        if (addr_q[1:0] == 2'(i)) begin
          merge_word[8*i +: 8] = wdata_q[7:0];
        end
      end
    end else begin
      if (addr_q[1]) begin
        merge_word[31:16] = wdata_q[15:0];
      end else begin
        merge_word[15:0] = wdata_q[15:0];
      end
    end
  end

  // ------------------------------------------------------------------------
  // Next-state and output logic
  // ------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    merged_d     = merged_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_a_c      = 32'h0;
    mem_we_c     = 1'b0;
    mem_wd_c     = 32'h0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_bad) begin
            state_d      = S_RESP;
            resp_rdata_d = 32'h0;
            resp_err_d   = 1'b1;
          end else if (!req_we) begin
            state_d = S_LD;
          end else if (req_funct3 == F3_W) begin
            state_d = S_ST;
          end else begin
            state_d = S_RMW_R;
          end
        end
      end

      S_LD: begin
        mem_a_c      = word_idx;
        resp_rdata_d = load_ext;
        resp_err_d   = 1'b0;
        state_d      = S_RESP;
      end

      S_ST: begin
        mem_a_c      = word_idx;
        mem_we_c     = 1'b1;
        mem_wd_c     = wdata_q;
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b0;
        state_d      = S_RESP;
      end

      S_RMW_R: begin
        mem_a_c  = word_idx;
        merged_d = merge_word;
        state_d  = S_RMW_W;
      end

      S_RMW_W: begin
        mem_a_c      = word_idx;
        mem_we_c     = 1'b1;
        mem_wd_c     = merged_q;
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b0;
        state_d      = S_RESP;
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= 32'h0;
      funct3_q     <= 3'b000;
      wdata_q      <= 32'h0;
      merged_q     <= 32'h0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      merged_q     <= merged_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      if (accept) begin
        addr_q   <= req_addr;
        funct3_q <= req_funct3;
        wdata_q  <= req_wdata;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Outputs. Reset gates the handshake and the memory port combinationally
  // so that a reset edge landing on a write cycle never commits the write.
  // ------------------------------------------------------------------------
  assign req_ready  = (state_q == S_IDLE) && !rst;
  assign resp_valid = (state_q == S_RESP) && !rst;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_a      = rst ? 32'h0 : mem_a_c;
  assign mem_we     = mem_we_c && !rst;
  assign mem_wd     = rst ? 32'h0 : mem_wd_c;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_ctrl
//
// Self-checking bench for lsu_mem_ctrl. A behavioural 1024 x 32 memory
// (combinational read, zero read data while writing, synchronous write) sits
// on the memory port. Expected responses are queued when a request is driven
// and popped when the response appears.
// ---------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.MEM_WORDS(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_a      (mem_a),
    .mem_we     (mem_we),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem [1024];
  int          we_count = 0;
  logic        pl_en = 1'b0;
  logic [9:0]  pl_a  = 10'd0;
  logic [31:0] pl_d  = 32'h0;

  assign mem_rd = (mem_we || (mem_a >= 32'd1024)) ? 32'h0 : mem[mem_a[9:0]];

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_a] <= pl_d;
    end else if (mem_we) begin
      mem[mem_a[9:0]] <= mem_wd;
      we_count        <= we_count + 1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wes;
  } exp_t;

  exp_t exp_q[$];

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Drives one request, waits (bounded) for acceptance and the response.
  // lat counts edges from the accept edge to the first cycle with resp_valid;
  // -1 means no response arrived. again is resp_valid one cycle later.
  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output logic e,
                       output int wes, output logic again);
    int w0;
    int n;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    w0 = we_count;
    n  = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid) lat = -1;
    rd = resp_rdata;
    e  = resp_err;
    @(posedge clk); #1;
    again = resp_valid;
    wes   = we_count - w0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    preload(10'd7, 32'h8070F020);
    preload(10'd1023, 32'h13579BDF);
    req_valid = 1'b1; req_addr = 32'h1C;
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", req_ready); end
    @(posedge clk); #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 00000000", resp_rdata); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", resp_err); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_loads();
    logic [31:0] la [10] = '{32'h1C, 32'h1F, 32'h1F, 32'h1E, 32'h1E,
                             32'h1C, 32'h1C, 32'h1D, 32'h1C, 32'hFFC};
    logic [2:0]  lf [10] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101,
                             3'b000, 3'b001, 3'b000, 3'b101, 3'b010};
    logic [31:0] ld [10] = '{32'h8070F020, 32'hFFFFFF80, 32'h00000080, 32'hFFFF8070, 32'h00008070,
                             32'h00000020, 32'hFFFFF020, 32'hFFFFFFF0, 32'h0000F020, 32'h13579BDF};
    exp_t ex; int lat; logic [31:0] rd; logic e; int wes; logic again;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back('{$sformatf("load%0d_a%h_f%b", i, la[i], lf[i]), ld[i], 1'b0, 2, 0});
      issue(1'b0, lf[i], la[i], 32'h0, lat, rd, e, wes, again);
      ex = exp_q.pop_front();
      total++; if (rd !== ex.rdata) begin bad++; $display("FAIL %s rdata: got %h want %h", ex.name, rd, ex.rdata); end
      total++; if (e !== ex.err) begin bad++; $display("FAIL %s err: got %b want %b", ex.name, e, ex.err); end
      total++; if (lat !== ex.lat) begin bad++; $display("FAIL %s latency: got %0d want %0d", ex.name, lat, ex.lat); end
      total++; if (wes !== ex.wes) begin bad++; $display("FAIL %s writes: got %0d want %0d", ex.name, wes, ex.wes); end
      total++; if (again !== 1'b0) begin bad++; $display("FAIL %s pulse_width: resp_valid still %b want 0", ex.name, again); end
    end
  endtask

  task automatic test_errors();
    logic        ew [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0]  ef [8] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b010, 3'b110};
    logic [31:0] ea [8] = '{32'h1E, 32'h1F, 32'h1000, 32'h1C, 32'h1C, 32'h1D, 32'h20000000, 32'h1C};
    exp_t ex; int lat; logic [31:0] rd; logic e; int wes; logic again;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back('{$sformatf("err%0d_we%b_a%h_f%b", i, ew[i], ea[i], ef[i]), 32'h0, 1'b1, 1, 0});
      issue(ew[i], ef[i], ea[i], 32'hA5A5A5A5, lat, rd, e, wes, again);
      ex = exp_q.pop_front();
      total++; if (rd !== ex.rdata) begin bad++; $display("FAIL %s rdata: got %h want %h", ex.name, rd, ex.rdata); end
      total++; if (e !== ex.err) begin bad++; $display("FAIL %s err: got %b want %b", ex.name, e, ex.err); end
      total++; if (lat !== ex.lat) begin bad++; $display("FAIL %s latency: got %0d want %0d", ex.name, lat, ex.lat); end
      total++; if (wes !== ex.wes) begin bad++; $display("FAIL %s writes: got %0d want %0d", ex.name, wes, ex.wes); end
      total++; if (again !== 1'b0) begin bad++; $display("FAIL %s pulse_width: resp_valid still %b want 0", ex.name, again); end
    end
    total++; if (mem[7] !== 32'h8070F020) begin bad++; $display("FAIL err_word7_intact: got %h want 8070F020", mem[7]); end
  endtask

  task automatic test_sub_word_stores();
    logic [2:0]  sf [3] = '{3'b000, 3'b001, 3'b000};
    logic [31:0] sa [3] = '{32'h1D, 32'h1E, 32'h1C};
    logic [31:0] sd [3] = '{32'h000000AB, 32'h00001234, 32'hCCCCCC11};
    logic [31:0] sw [3] = '{32'h8070AB20, 32'h1234AB20, 32'h1234AB11};
    exp_t ex; int lat; logic [31:0] rd; logic e; int wes; logic again;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{$sformatf("rmw%0d_a%h_f%b", i, sa[i], sf[i]), 32'h0, 1'b0, 3, 1});
      issue(1'b1, sf[i], sa[i], sd[i], lat, rd, e, wes, again);
      ex = exp_q.pop_front();
      total++; if (rd !== ex.rdata) begin bad++; $display("FAIL %s rdata: got %h want %h", ex.name, rd, ex.rdata); end
      total++; if (e !== ex.err) begin bad++; $display("FAIL %s err: got %b want %b", ex.name, e, ex.err); end
      total++; if (lat !== ex.lat) begin bad++; $display("FAIL %s latency: got %0d want %0d", ex.name, lat, ex.lat); end
      total++; if (wes !== ex.wes) begin bad++; $display("FAIL %s writes: got %0d want %0d", ex.name, wes, ex.wes); end
      total++; if (mem[7] !== sw[i]) begin bad++; $display("FAIL %s word7: got %h want %h", ex.name, mem[7], sw[i]); end
    end
  endtask

  task automatic test_sw();
    exp_t ex; int lat; logic [31:0] rd; logic e; int wes; logic again;
    exp_q.push_back('{"sw_0x28", 32'h0, 1'b0, 2, 1});
    issue(1'b1, 3'b010, 32'h28, 32'hDEADBEEF, lat, rd, e, wes, again);
    ex = exp_q.pop_front();
    total++; if (rd !== ex.rdata) begin bad++; $display("FAIL %s rdata: got %h want %h", ex.name, rd, ex.rdata); end
    total++; if (e !== ex.err) begin bad++; $display("FAIL %s err: got %b want %b", ex.name, e, ex.err); end
    total++; if (lat !== ex.lat) begin bad++; $display("FAIL %s latency: got %0d want %0d", ex.name, lat, ex.lat); end
    total++; if (wes !== ex.wes) begin bad++; $display("FAIL %s writes: got %0d want %0d", ex.name, wes, ex.wes); end
    total++; if (mem[10] !== 32'hDEADBEEF) begin bad++; $display("FAIL %s word10: got %h want DEADBEEF", ex.name, mem[10]); end
    total++; if (mem[7] !== 32'h1234AB11) begin bad++; $display("FAIL %s word7_intact: got %h want 1234AB11", ex.name, mem[7]); end
  endtask

  task automatic test_reset_mid_op();
    exp_t ex; int lat; logic [31:0] rd; logic e; int wes; logic again; int wc; int seen;
    // Leave a non-zero response registered so the reset clear is visible.
    exp_q.push_back('{"pre_reset_lw", 32'h1234AB11, 1'b0, 2, 0});
    issue(1'b0, 3'b010, 32'h1C, 32'h0, lat, rd, e, wes, again);
    ex = exp_q.pop_front();
    total++; if (rd !== ex.rdata) begin bad++; $display("FAIL %s rdata: got %h want %h", ex.name, rd, ex.rdata); end
    wc = we_count;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h1C; req_wdata = 32'h000000FF;
    @(posedge clk); #1;          // accepted -> RMW_R
    req_valid = 1'b0;
    @(posedge clk); #1;          // RMW_W
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL rstmid_rmw_w_we: got %b want 1", mem_we); end
    rst = 1'b1;
    #1;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rstmid_we_gated: got %b want 0", mem_we); end
    @(posedge clk); #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rstmid_resp_valid: got %b want 0", resp_valid); end
    total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL rstmid_rdata: got %h want 00000000", resp_rdata); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL rstmid_err: got %b want 0", resp_err); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rstmid_ready_in_rst: got %b want 0", req_ready); end
    rst = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready_after: got %b want 1", req_ready); end
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_no_resp: got %0d pulses want 0", seen); end
    total++; if (mem[7] !== 32'h1234AB11) begin bad++; $display("FAIL rstmid_word7: got %h want 1234AB11", mem[7]); end
    total++; if (we_count !== wc) begin bad++; $display("FAIL rstmid_writes: got %0d want %0d", we_count - wc, 0); end
  endtask

  task automatic test_back_to_back();
    exp_t ex; int n;
    exp_q.push_back('{"b2b_first", 32'h1234AB11, 1'b0, 2, 0});
    exp_q.push_back('{"b2b_second", 32'hDEADBEEF, 1'b0, 2, 0});
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h1C; req_wdata = 32'h0;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;          // first accepted -> LD
    req_addr = 32'h28;           // valid stays high
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_ld: got %b want 0", req_ready); end
    @(posedge clk); #1;          // RESP of first
    ex = exp_q.pop_front();
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL %s valid: got %b want 1", ex.name, resp_valid); end
    total++; if (resp_rdata !== ex.rdata) begin bad++; $display("FAIL %s rdata: got %h want %h", ex.name, resp_rdata, ex.rdata); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_resp: got %b want 0", req_ready); end
    @(posedge clk); #1;          // IDLE; second accepted at the next edge
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_idle: got %b want 1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL b2b_gap: resp_valid got %b want 0", resp_valid); end
    @(posedge clk); #1;          // second in LD
    req_valid = 1'b0;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_ld2: got %b want 0", req_ready); end
    @(posedge clk); #1;          // RESP of second
    ex = exp_q.pop_front();
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL %s valid: got %b want 1", ex.name, resp_valid); end
    total++; if (resp_rdata !== ex.rdata) begin bad++; $display("FAIL %s rdata: got %h want %h", ex.name, resp_rdata, ex.rdata); end
    total++; if (resp_err !== ex.err) begin bad++; $display("FAIL %s err: got %b want %b", ex.name, resp_err, ex.err); end
    @(posedge clk); #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL b2b_end: resp_valid got %b want 0", resp_valid); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_errors();
    test_sub_word_stores();
    test_sw();
    test_reset_mid_op();
    test_back_to_back();
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
